// File: rtl/clock_pkg.sv
// Shared definitions for the BCD clock timer: control codes, FSM states,
// digit limits, bus field offsets and the BCD increment helpers.
package clock_pkg;

  // Control codes arriving from the push-button block.
  localparam logic [3:0] ST_RESET = 4'd0;
  localparam logic [3:0] ST_SET   = 4'd1;
  localparam logic [3:0] ST_LOAD  = 4'd2;
  localparam logic [3:0] ST_START = 4'd3;
  localparam logic [3:0] ST_IDLE  = 4'd4;

  // Internal clock FSM.
  typedef enum logic [1:0] {
    HOLD = 2'd0,
    SET  = 2'd1,
    RUN  = 2'd2
  } fsm_t;

  // Digit maxima; the hour pair uses its own 12-hour limit.
  localparam logic [3:0] MAX_UNITS  = 4'd9;
  localparam logic [3:0] MAX_TENS   = 4'd5;
  localparam logic [7:0] HOUR_LIMIT = 8'h12;

  // LSB positions of each digit on the 24-bit hh:mm:ss bus.
  localparam int HT_LSB = 20;
  localparam int HU_LSB = 16;
  localparam int MT_LSB = 12;
  localparam int MU_LSB = 8;
  localparam int ST_LSB = 4;
  localparam int SU_LSB = 0;

  // One BCD digit step: anything at or above the maximum (illegal codes
  // included) rolls to zero.
  function automatic logic [3:0] digit_inc(input logic [3:0] d, input logic [3:0] max);
    return (d >= max) ? 4'd0 : d + 4'd1;
  endfunction

  // Two-digit hour step on a 12-hour dial: 12 and anything above go to 01,
  // a units digit of 9 or more carries into the tens, 00 becomes 01.
  function automatic logic [7:0] hour_inc(input logic [7:0] h);
    logic [7:0] r;
    if (h >= HOUR_LIMIT) begin
      r = 8'h01;
    end else if (h[3:0] >= MAX_UNITS) begin
      // Only reachable with tens = 0 below the limit: 09 (or 0A-0F) -> 10.
      r = {h[7:4] + 4'd1, 4'd0};
    end else begin
      // Covers 00 -> 01 as well as the ordinary +1 cases.
      r = h + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit with clear, parallel load and ripple carry.
module bcd_digit_counter
  import clock_pkg::*;
#(
  parameter logic [3:0] MAX = MAX_UNITS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       carry_in,
  output logic [3:0] digit,
  output logic       carry_out
);

  // Carry ripples on when this digit wraps.
  assign carry_out = carry_in && (digit >= MAX);

  // Digit register: clear beats load beats count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= 4'd0;
    end else if (clear) begin
      digit <= 4'd0;
    end else if (load) begin
      digit <= load_value;
    end else if (carry_in) begin
      digit <= digit_inc(digit, MAX);
    end
  end

endmodule

// File: rtl/bcd_clock_timer.sv
// 12-hour BCD timekeeping core driven by the control block's state code.
// Optional dose alarm compiled in with `define ALARM_EN.
//
// Handshake note: there is no valid/ready pair here. The control code is
// level-based; it is registered once and the registered code is decoded
// each cycle, so a code takes effect on the edge after it is sampled.
module bcd_clock_timer
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  state,
  input  logic [23:0] time_in,
`ifdef ALARM_EN
  input  logic [23:0] alarm_time,
  output logic        alarm,
`endif
  output logic [23:0] time_out,
  output logic        running,
  output logic        sec_tick
);

  localparam int          PW   = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICKS_PER_SEC - 1);

  logic [3:0]    code_q;
  fsm_t          fsm_state;
  fsm_t          fsm_next;
  logic          do_clear;
  logic          do_load;
  logic          do_start;
  logic          do_count;
  logic          tick_now;
  logic [PW-1:0] prescaler;
  logic [7:0]    hour;
  logic [3:0]    su, st, mu, mt;
  logic          su_carry, st_carry, mu_carry, mt_carry;

  // Register the incoming control code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= ST_RESET;
    end else begin
      code_q <= state;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_state <= HOLD;
    end else begin
      fsm_state <= fsm_next;
    end
  end

  // Decode the registered code into the next FSM state and datapath strobes.
  always_comb begin
    fsm_next = fsm_state;
    do_clear = 1'b0;
    do_load  = 1'b0;
    do_start = 1'b0;
    // Time only advances in RUN, and a clear on the terminal cycle wins.
    do_count = (fsm_state == RUN) && (code_q != ST_RESET);
    case (code_q)
      ST_RESET: begin
        fsm_next = HOLD;
        do_clear = 1'b1;
      end
      ST_SET: begin
        if (fsm_state != RUN) begin
          fsm_next = SET;
          do_load  = 1'b1;
        end
      end
      ST_LOAD: begin
        if (fsm_state != RUN) begin
          fsm_next = HOLD;
        end
      end
      ST_START: begin
        fsm_next = RUN;
        // Re-asserting start while running leaves the prescaler alone.
        if (fsm_state != RUN) begin
          do_start = 1'b1;
        end
      end
      default: begin
        fsm_next = fsm_state;
      end
    endcase
  end

  assign tick_now = do_count && (prescaler == TERM);
  assign running  = (fsm_state == RUN);

  // One-second prescaler: zeroed on clear or RUN entry, wraps at terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
    end else if (do_clear || do_start) begin
      prescaler <= '0;
    end else if (do_count) begin
      prescaler <= tick_now ? '0 : prescaler + 1'b1;
    end
  end

  // Tick pulse lands on the same edge as the time increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_tick <= 1'b0;
    end else begin
      sec_tick <= tick_now;
    end
  end

  bcd_digit_counter #(.MAX(MAX_UNITS)) u_sec_units (
    .clk(clk), .rst_n(rst_n), .clear(do_clear), .load(do_load),
    .load_value(time_in[SU_LSB +: 4]), .carry_in(tick_now),
    .digit(su), .carry_out(su_carry)
  );

  bcd_digit_counter #(.MAX(MAX_TENS)) u_sec_tens (
    .clk(clk), .rst_n(rst_n), .clear(do_clear), .load(do_load),
    .load_value(time_in[ST_LSB +: 4]), .carry_in(su_carry),
    .digit(st), .carry_out(st_carry)
  );

  bcd_digit_counter #(.MAX(MAX_UNITS)) u_min_units (
    .clk(clk), .rst_n(rst_n), .clear(do_clear), .load(do_load),
    .load_value(time_in[MU_LSB +: 4]), .carry_in(st_carry),
    .digit(mu), .carry_out(mu_carry)
  );

  bcd_digit_counter #(.MAX(MAX_TENS)) u_min_tens (
    .clk(clk), .rst_n(rst_n), .clear(do_clear), .load(do_load),
    .load_value(time_in[MT_LSB +: 4]), .carry_in(mu_carry),
    .digit(mt), .carry_out(mt_carry)
  );

  // Hour pair kept inline because of the 12 -> 01 wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hour <= 8'h00;
    end else if (do_clear) begin
      hour <= 8'h00;
    end else if (do_load) begin
      hour <= time_in[HU_LSB +: 8];
    end else if (mt_carry) begin
      hour <= hour_inc(hour);
    end
  end

  assign time_out = {hour, mt, mu, st, su};

`ifdef ALARM_EN
  logic [23:0] time_next;

  // Value the time bus will hold after this edge's increment.
  always_comb begin
    time_next = time_out;
    time_next[SU_LSB +: 4] = tick_now ? digit_inc(su, MAX_UNITS) : su;
    time_next[ST_LSB +: 4] = su_carry ? digit_inc(st, MAX_TENS)  : st;
    time_next[MU_LSB +: 4] = st_carry ? digit_inc(mu, MAX_UNITS) : mu;
    time_next[MT_LSB +: 4] = mu_carry ? digit_inc(mt, MAX_TENS)  : mt;
    time_next[HU_LSB +: 8] = mt_carry ? hour_inc(hour)           : hour;
  end

  // Sticky dose alarm: set by an increment that lands on alarm_time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm <= 1'b0;
    end else if (do_clear) begin
      alarm <= 1'b0;
    end else if (tick_now && (time_next == alarm_time)) begin
      alarm <= 1'b1;
    end else if (code_q == ST_SET) begin
      alarm <= 1'b0;
    end
  end
`endif

endmodule
